banked_data_memory: RTL
=======================

Name: banked_data_memory

Overview:
- Parametrised word-addressed data memory for the RISC-V core and test harness.
- Replaces the flat single-cycle RAM with:
  - a valid/ready request port;
  - per-byte write strobes for sb/sh/sw;
  - configurable read latency;
  - a buffered response port that tolerates back-pressure.
- Out-of-range accesses return zero data and an error flag; writes are never silently lost or spilled.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word width; multiple of 8, power of two.
- DEPTH_WORDS, 262144, number of words implemented.
- READ_LATENCY, 1, cycles from request accept to response-FIFO entry; legal 1..4.
- RSP_DEPTH, 4, response FIFO entries; must be at least READ_LATENCY+1.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, request can be accepted this cycle.
- req_we, input, 1, 1 = write, 0 = read.
- req_addr, input, ADDR_WIDTH, byte address.
- req_wdata, input, DATA_WIDTH, write data.
- req_wstrb, input, DATA_WIDTH/8, byte write enables; ignored on reads.
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, consumer takes response.
- rsp_rdata, output, DATA_WIDTH, read data; zero for writes and errors.
- rsp_err, output, 1, address out of range (or misaligned, see Optional Feature).

Behaviour:
- Word index
  - idx = req_addr >> log2(DATA_WIDTH/8).
  - In range iff idx < DEPTH_WORDS; compare at full width, no truncation.
- Accept
  - A request is accepted when req_valid && req_ready at posedge.
- Every accepted request produces exactly one response, reads and writes alike, in accept order.
- Credit counter
  - outstanding = requests in pipeline + entries in FIFO.
  - +1 on accept, -1 on response pop (rsp_valid && rsp_ready); both in the same cycle leave it unchanged.
  - req_ready = (outstanding < RSP_DEPTH), combinational from registered state only; no dependency on req_valid.
- Writes
  - On accept with req_we=1 and idx in range, byte lane b of RAM[idx] is updated iff req_wstrb[b].
  - Takes effect at that posedge.
  - Out-of-range write: no RAM change, response has rsp_err=1.
- Reads
  - RAM sampled at the accept edge; data travels READ_LATENCY-1 further register stages, then is pushed into the FIFO.
  - Entry is visible on rsp_* READ_LATENCY cycles after accept if the FIFO was empty.
  - Out-of-range read: rdata=0, err=1.
- Ordering
  - A read accepted the cycle after a write to the same word returns the new data.
  - Only one request per cycle, so no same-edge conflict exists.
- Response FIFO
  - Head drives rsp_*; rsp_valid = not empty.
  - rsp_* must hold stable while rsp_valid && !rsp_ready.
  - Push and pop in the same cycle are both honoured.
  - Pointers wrap modulo RSP_DEPTH.
  - Overflow is impossible by the credit rule.
- Latency=1 with empty FIFO and rsp_ready held high: sustained throughput of one request per cycle.
- Reset (rst_n low, asynchronous)
  - Clears pipeline valids, FIFO pointers and count, credit counter.
  - rsp_valid=0; rsp_rdata=0; rsp_err=0; req_ready=1 (after counter clear).
  - In-flight requests are discarded.
  - RAM contents are not reset and are preserved across reset.
- Reset deassertion is assumed synchronised externally; no request is accepted in the cycle rst_n rises.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined:
  - Any request with nonzero req_addr[log2(DATA_WIDTH/8)-1:0] is misaligned.
  - A misaligned write does not modify RAM.
  - Both misaligned reads and writes respond with rsp_err=1, rdata=0.
  - rsp_err is the OR of out-of-range and misaligned.
- When undefined:
  - Low address bits are ignored; the access targets the containing word.
  - rsp_err reflects range only.

Test Plan:
- Write 0xDEADBEEF to 0x100, strb=4'hF; read 0x100 -> rdata=0xDEADBEEF, err=0, response READ_LATENCY cycles after accept.
- Preload 0x11223344 at 0x40; write 0xAABBCCDD strb=4'b0101; read -> 0x11BB33DD.
- Read at byte address DEPTH_WORDS*4 -> err=1, rdata=0; write there, then read word 0 -> unchanged.
- rsp_ready=0, issue 6 reads with RSP_DEPTH=4 -> req_ready drops after the 4th accept.
  - Head response held stable.
  - Releasing rsp_ready returns 4 then 2 responses in order with correct data.
- Back-to-back write 0x5 then read same word in the next cycle, READ_LATENCY=3 -> read returns 0x5.
  - Two-cycle reset pulse mid-stream -> rsp_valid=0, req_ready=1.
  - Old data retained on re-read.
- With DMEM_ALIGN_CHECK_EN: write to 0x102 -> err=1, RAM unchanged.
- Without DMEM_ALIGN_CHECK_EN: the same write updates word 0x100.

Source files
------------

// File: rtl/banked_data_memory.sv
// banked_data_memory: word-addressed data memory with a valid/ready request
// port, per-byte write strobes, a READ_LATENCY-deep read pipeline and a
// credit-protected response FIFO that tolerates back-pressure.
// Every accepted request (read or write) yields exactly one response, in order.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned accesses flag rsp_err
// and never modify memory).
module banked_data_memory #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 262144,
  parameter int READ_LATENCY = 1,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

  // Request decode
  logic [ADDR_WIDTH-1:0] idx;
  logic [IDX_W-1:0]      mem_idx;
  logic                  in_range;
  logic                  misalign;
  logic                  req_err;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  wr_en;

  assign idx      = req_addr >> OFF;
  assign mem_idx  = idx[IDX_W-1:0];
  // Compare the whole word index so huge addresses never alias onto low words.
  assign in_range = {1'b0, idx} < (ADDR_WIDTH + 1)'(DEPTH_WORDS);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = (req_addr & ADDR_WIDTH'(STRB_W - 1)) != '0;
`else
  assign misalign = 1'b0;
`endif

  assign req_err = !in_range || misalign;
  assign accept  = req_valid && req_ready;
  assign wr_en   = accept && req_we && !req_err;

  // Storage and read pipeline
  logic [DATA_WIDTH-1:0] mem       [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] pipe_data [READ_LATENCY];
  logic                  pipe_err  [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_valid;

  // RAM write with byte strobes, RAM sample at the accept edge, data stage shift.
  // NOTE: memory and datapath registers carry no reset; only control state
  // (valids, pointers, counters) is reset, so RAM contents survive rst_n.
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (wr_en && req_wstrb[b]) begin
        // NOTE: non-blocking, so a read on this same edge still sees old data.
        mem[mem_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
    pipe_data[0] <= (!req_we && !req_err) ? mem[mem_idx] : '0;
    pipe_err[0]  <= req_err;
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_data[k] <= pipe_data[k-1];
      pipe_err[k]  <= pipe_err[k-1];
    end
  end

  // Pipeline valid bits track accepted requests toward the response FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
      end
    end
  end

  assign push = pipe_valid[READ_LATENCY-1];

  // Response FIFO
  logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic                  fifo_err  [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      outstanding;

  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  // Gate the head with rsp_valid so outputs read zero while the FIFO is empty.
  assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign rsp_err   = rsp_valid ? fifo_err[rd_ptr]  : 1'b0;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO entry storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= pipe_data[READ_LATENCY-1];
      fifo_err[wr_ptr]  <= pipe_err[READ_LATENCY-1];
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle are both honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Credit counter: requests in the pipeline plus entries in the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Depends only on registered state, never on req_valid.
  assign req_ready = (outstanding < CNT_W'(RSP_DEPTH));

endmodule
